// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator: MSB-first pattern serializer with repeat count,
// idle gap between repetitions and out_ready backpressure.
module serial_pattern_generator #(
  parameter int PATTERN_W = 6,
  parameter int CNT_W = 4,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_cnt,
  output logic                 out_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = $clog2(PATTERN_W);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(PATTERN_W - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t               r_state;
  logic [PATTERN_W-1:0] r_pat;
  logic [CNT_W-1:0]     r_rem;
  logic [IW-1:0]        r_idx;
  logic [GW-1:0]        r_gap;
  logic                 r_bit;
  logic                 r_valid;
  logic                 r_done;
  assign start_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign out_bit = r_bit;
  assign out_valid = r_valid;
  assign done = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat <= '0;
      r_rem <= '0;
      r_idx <= '0;
      r_gap <= '0;
      r_bit <= IDLE_BIT;
      r_valid <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start_valid) begin
          r_state <= SEND;
          r_pat <= pattern;
          r_rem <= repeat_cnt == '0 ? CNT_W'(1) : repeat_cnt;
          r_idx <= LAST;
          r_bit <= pattern[PATTERN_W-1];
          r_valid <= 1'b1;
        end
        SEND: if (out_ready) begin
          if (r_idx != '0) begin
            r_idx <= r_idx - 1'b1;
            r_bit <= r_pat[r_idx - 1'b1];
          end else begin
            // r_rem is at least 1 here, so the decrement never wraps
            r_rem <= r_rem - 1'b1;
            if (r_rem == CNT_W'(1)) begin
              r_state <= IDLE;
              r_bit <= IDLE_BIT;
              r_valid <= 1'b0;
              r_done <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              r_idx <= LAST;
              r_bit <= r_pat[PATTERN_W-1];
            end else begin
              r_state <= GAP;
              r_gap <= GAP_INIT;
              r_bit <= IDLE_BIT;
              r_valid <= 1'b0;
            end
          end
        end
        GAP: if (r_gap == '0) begin
          r_state <= SEND;
          r_idx <= LAST;
          r_bit <= r_pat[PATTERN_W-1];
          r_valid <= 1'b1;
        end else begin
          r_gap <= r_gap - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_pattern_generator.sv
// tb_serial_pattern_generator: scoreboard bench for two generator instances (gap 2 and gap 0) sharing stimulus.
module tb_serial_pattern_generator;
  localparam int W = 6;
  localparam int CW = 4;
  localparam bit IDLE = 1'b0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [CW-1:0] repeat_cnt = '0;
  logic out_ready = 1'b1;
  logic [1:0] sr, bz, dn, ob, ov;
  int n_checks = 0;
  int n_fail = 0;
  int gaps [2] = '{2, 0};
  bit q [2][$];
  bit exp_done [2];
  bit first [2];
  int run [2];
  bit armed = 1'b0;
  bit idle;
  always #5 clk = ~clk;
  serial_pattern_generator #(.PATTERN_W(W), .CNT_W(CW), .GAP_CYCLES(2), .IDLE_BIT(IDLE)) u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[0]), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .out_bit(ob[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .busy(bz[0]), .done(dn[0]));
  serial_pattern_generator #(.PATTERN_W(W), .CNT_W(CW), .GAP_CYCLES(0), .IDLE_BIT(IDLE)) u_dut0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[1]), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .out_bit(ob[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .busy(bz[1]), .done(dn[1]));
  function automatic void chk(string name, int k, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endfunction
  // Model: idle whenever every expected bit has been transferred; each accept queues the full bit stream.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        exp_done[k] = 1'b0;
        first[k] = 1'b0;
        run[k] = 0;
        armed = 1'b1;
      end else if (armed) begin
        idle = q[k].size() == 0;
        chk("start_ready", k, sr[k], idle);
        chk("busy", k, bz[k], !idle);
        chk("done", k, dn[k], exp_done[k]);
        if (first[k]) chk("first_bit_latency", k, ov[k], 1);
        first[k] = 1'b0;
        exp_done[k] = 1'b0;
        if (ov[k]) begin
          if (run[k] != 0) chk("gap_len", k, run[k], gaps[k]);
          run[k] = 0;
          if (idle) chk("valid_when_idle", k, ov[k], 0);
          else begin
            chk("out_bit", k, ob[k], q[k][0]);
            if (out_ready) begin
              void'(q[k].pop_front());
              if (q[k].size() == 0) exp_done[k] = 1'b1;
            end
          end
        end else begin
          chk("idle_bit", k, ob[k], IDLE);
          if (!idle) run[k]++;
        end
        if (idle && start_valid) begin
          for (int r = 0; r < (repeat_cnt == 0 ? 1 : int'(repeat_cnt)); r++)
            for (int i = W - 1; i >= 0; i--) q[k].push_back(pattern[i]);
          first[k] = 1'b1;
        end
      end
    end
  end
  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (sr == 2'b11 && bz == 2'b00) return;
    end
    chk("idle_timeout", 0, 0, 1);
  endtask
  task automatic start(input logic [W-1:0] p, input logic [CW-1:0] c);
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    pattern = p;
    repeat_cnt = c;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    pattern = ~p;
    repeat_cnt = c + 1'b1;
  endtask
  task automatic measure(input int k, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (dn[k]) break;
    end
    chk("cycles_to_done", k, n, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    start(6'b110011, 4'd1);
    measure(0, 7);
    wait_idle();
    start(6'b110011, 4'd3);
    measure(0, 23);
    wait_idle();
    start(6'b110011, 4'd1);
    @(posedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    start(6'b101101, 4'd2);
    @(posedge clk);
    #1;
    start_valid = 1'b1;
    pattern = 6'b010010;
    repeat_cnt = 4'd5;
    repeat (3) @(posedge clk);
    #1 start_valid = 1'b0;
    wait_idle();
    start(6'b111000, 4'd2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    start(6'b100110, 4'd0);
    measure(0, 7);
    wait_idle();
    start(6'b011011, 4'd2);
    measure(1, 13);
    wait_idle();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      start_valid = ($urandom % 6) == 0;
      pattern = W'($urandom);
      repeat_cnt = CW'($urandom_range(0, 3));
      out_ready = ($urandom % 4) != 0;
      rst = ($urandom % 300) == 0;
    end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
